// File: rtl/adder_pkg.sv
// Shared definitions for the sliced adder: FSM encoding and slice arithmetic.
package adder_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of whole slices that fit in num_bits; the caller checks the remainder.
  function automatic int unsigned slice_count(input int unsigned num_bits,
                                              input int unsigned slice_bits);
    return num_bits / slice_bits;
  endfunction

endpackage

// File: rtl/sliced_adder_nbit_if.sv
// Request/result bundle for the sliced adder (start/busy/done handshake).
interface sliced_adder_nbit_if #(
  parameter int unsigned NUM_BITS = 16
);
  logic                start;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                carry_in;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] sum;
  logic                overflow;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, overflow
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, overflow
  );
endinterface

// File: rtl/adder_nbit.sv
// Combinational WIDTH-bit adder with carry in and carry out.
module adder_nbit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/sliced_adder_nbit.sv
// Multi-cycle unsigned adder: one SLICE_BITS slice per clock, LSB slice first,
// carry registered between slices.
module sliced_adder_nbit
  import adder_pkg::*;
#(
  parameter int unsigned NUM_BITS   = 16,
  parameter int unsigned SLICE_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  sliced_adder_nbit_if.slave bus
);

  localparam int unsigned NUM_SLICES = slice_count(NUM_BITS, SLICE_BITS);
  localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  if (NUM_BITS < 2) begin : g_bad_width
    $error("sliced_adder_nbit: NUM_BITS must be >= 2");
  end
  if (NUM_SLICES * SLICE_BITS != NUM_BITS) begin : g_bad_slice
    $error("sliced_adder_nbit: SLICE_BITS must divide NUM_BITS");
  end

  state_t                state_q, state_d;
  logic [NUM_BITS-1:0]   op_a, op_b, acc, acc_d, sum_q;
  logic                  carry_q, ovf_q;
  logic [IDX_W-1:0]      idx;
  logic [SLICE_BITS-1:0] sl_a, sl_b, sl_sum;
  logic                  sl_carry;
  logic                  accept, last;

  assign accept = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (idx == LAST_IDX);

  assign sl_a = op_a[idx*SLICE_BITS +: SLICE_BITS];
  assign sl_b = op_b[idx*SLICE_BITS +: SLICE_BITS];

  adder_nbit #(.WIDTH(SLICE_BITS)) u_slice (
    .a        (sl_a),
    .b        (sl_b),
    .carry_in (carry_q),
    .sum      (sl_sum),
    .overflow (sl_carry)
  );

  // Accumulator with the current slice merged in, so the completing edge
  // can publish the full result in the same cycle.
  always_comb begin
    acc_d = acc;
    acc_d[idx*SLICE_BITS +: SLICE_BITS] = sl_sum;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (last)      state_d = DONE;
      DONE:    state_d = bus.start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-slice accumulation and result publication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      op_a    <= bus.a;
      op_b    <= bus.b;
      carry_q <= bus.carry_in;
      idx     <= '0;
    end else if (state_q == CALC) begin
      acc     <= acc_d;
      carry_q <= sl_carry;
      idx     <= idx + 1'b1;
      if (last) begin
        sum_q <= acc_d;
        ovf_q <= sl_carry;
      end
    end
  end

  assign bus.busy     = (state_q == CALC);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_sliced_adder_nbit.sv
// Directed bench for sliced_adder_nbit at 16/4 plus a 32/8 instance.
module tb_sliced_adder_nbit;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sliced_adder_nbit_if #(.NUM_BITS(16)) bus16 ();
  sliced_adder_nbit_if #(.NUM_BITS(32)) bus32 ();

  sliced_adder_nbit #(.NUM_BITS(16), .SLICE_BITS(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  sliced_adder_nbit #(.NUM_BITS(32), .SLICE_BITS(8)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  task automatic start16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus16.a = a; bus16.b = b; bus16.carry_in = cin; bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
  endtask

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic cin);
    bus32.a = a; bus32.b = b; bus32.carry_in = cin; bus32.start = 1'b1;
    @(negedge clk);
    bus32.start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus16.busy !== 1'b0 || bus16.done !== 1'b0) begin
      bad++; $display("FAIL reset_flags16 got busy=%b done=%b want 0 0", bus16.busy, bus16.done);
    end
    total++;
    if (bus16.sum !== 16'h0000 || bus16.overflow !== 1'b0) begin
      bad++; $display("FAIL reset_sum16 got %h/%b want 0000/0", bus16.sum, bus16.overflow);
    end
    total++;
    if (bus32.busy !== 1'b0 || bus32.done !== 1'b0 || bus32.sum !== 32'h0) begin
      bad++; $display("FAIL reset32 got busy=%b done=%b sum=%h want 0 0 0", bus32.busy, bus32.done, bus32.sum);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zeros;
    start16(16'h0000, 16'h0000, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (bus16.busy !== 1'b1 || bus16.done !== 1'b0) begin
        bad++; $display("FAIL zeros_busy k=%0d got busy=%b done=%b want 1 0", k, bus16.busy, bus16.done);
      end
      @(negedge clk);
    end
    total++;
    if (bus16.done !== 1'b1 || bus16.busy !== 1'b0) begin
      bad++; $display("FAIL zeros_done got busy=%b done=%b want 0 1", bus16.busy, bus16.done);
    end
    total++;
    if (bus16.sum !== 16'h0000 || bus16.overflow !== 1'b0) begin
      bad++; $display("FAIL zeros_sum got %h/%b want 0000/0", bus16.sum, bus16.overflow);
    end
    @(negedge clk);
    total++;
    if (bus16.done !== 1'b0) begin
      bad++; $display("FAIL zeros_pulse got done=%b want 0", bus16.done);
    end
  endtask

  task automatic test_large;
    start16(16'hAAAA, 16'hBBBB, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      total++;
      if (bus16.sum !== 16'h0000 || bus16.done !== 1'b0) begin
        bad++; $display("FAIL large_hold k=%0d got sum=%h done=%b want 0000 0", k, bus16.sum, bus16.done);
      end
      @(negedge clk);
    end
    total++;
    if (bus16.done !== 1'b1 || bus16.sum !== 16'h6665 || bus16.overflow !== 1'b1) begin
      bad++; $display("FAIL large_sum got done=%b %h/%b want 1 6665/1", bus16.done, bus16.sum, bus16.overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_ripple;
    int n;
    start16(16'hFFFF, 16'h0000, 1'b1);
    n = 1;
    while (bus16.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n != 5) begin bad++; $display("FAIL ripple_latency got %0d want 5", n); end
    total++;
    if (bus16.sum !== 16'h0000 || bus16.overflow !== 1'b1) begin
      bad++; $display("FAIL ripple_full got %h/%b want 0000/1", bus16.sum, bus16.overflow);
    end
    @(negedge clk);
    start16(16'h0001, 16'h0002, 1'b0);
    n = 1;
    while (bus16.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n != 5 || bus16.sum !== 16'h0003 || bus16.overflow !== 1'b0) begin
      bad++; $display("FAIL ripple_small got lat=%0d %h/%b want 5 0003/0", n, bus16.sum, bus16.overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_collision;
    int n;
    bus16.a = 16'h1234; bus16.b = 16'h1111; bus16.carry_in = 1'b0; bus16.start = 1'b1;
    @(negedge clk);
    bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    n = 2;
    while (bus16.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n != 5 || bus16.sum !== 16'h2345 || bus16.overflow !== 1'b0) begin
      bad++; $display("FAIL collision_sum got lat=%0d %h/%b want 5 2345/0", n, bus16.sum, bus16.overflow);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (bus16.done !== 1'b0 || bus16.busy !== 1'b0 || bus16.sum !== 16'h2345) begin
        bad++; $display("FAIL collision_single k=%0d got done=%b busy=%b sum=%h want 0 0 2345",
                        k, bus16.done, bus16.busy, bus16.sum);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    start16(16'h4444, 16'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (bus16.busy !== 1'b0 || bus16.done !== 1'b0 || bus16.sum !== 16'h0000 || bus16.overflow !== 1'b0) begin
      bad++; $display("FAIL midreset_clear got busy=%b done=%b %h/%b want 0 0 0000/0",
                      bus16.busy, bus16.done, bus16.sum, bus16.overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (bus16.done !== 1'b0 || bus16.busy !== 1'b0) begin
        bad++; $display("FAIL midreset_quiet k=%0d got done=%b busy=%b want 0 0", k, bus16.done, bus16.busy);
      end
    end
    start16(16'h0FFF, 16'h0001, 1'b0);
    n = 1;
    while (bus16.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n != 5 || bus16.sum !== 16'h1000 || bus16.overflow !== 1'b0) begin
      bad++; $display("FAIL midreset_next got lat=%0d %h/%b want 5 1000/0", n, bus16.sum, bus16.overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    bus16.a = 16'h0101; bus16.b = 16'h0202; bus16.carry_in = 1'b0; bus16.start = 1'b1;
    @(negedge clk);
    n = 1;
    while (bus16.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n != 5 || bus16.sum !== 16'h0303 || bus16.overflow !== 1'b0) begin
      bad++; $display("FAIL b2b_first got lat=%0d %h/%b want 5 0303/0", n, bus16.sum, bus16.overflow);
    end
    bus16.a = 16'h8000; bus16.b = 16'h8000;
    @(negedge clk);
    bus16.start = 1'b0;
    n = 1;
    while (bus16.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n != 5) begin bad++; $display("FAIL b2b_spacing got %0d want 5", n); end
    total++;
    if (bus16.sum !== 16'h0000 || bus16.overflow !== 1'b1) begin
      bad++; $display("FAIL b2b_second got %h/%b want 0000/1", bus16.sum, bus16.overflow);
    end
    @(negedge clk);
  endtask

  task automatic test_wide;
    int n;
    logic [31:0] va, vb;
    logic        vc;
    logic [32:0] exp;
    start32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    n = 1;
    while (bus32.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (n != 5 || bus32.sum !== 32'h0000_0000 || bus32.overflow !== 1'b1) begin
      bad++; $display("FAIL wide_full got lat=%0d %h/%b want 5 00000000/1", n, bus32.sum, bus32.overflow);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      va  = $urandom;
      vb  = $urandom;
      vc  = 1'($urandom_range(0, 1));
      exp = {1'b0, va} + {1'b0, vb} + {32'h0, vc};
      start32(va, vb, vc);
      n = 1;
      while (bus32.done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      total++;
      if (n != 5 || {bus32.overflow, bus32.sum} !== exp) begin
        bad++; $display("FAIL wide_rand%0d a=%h b=%h c=%b got lat=%0d %b/%h want 5 %b/%h",
                        i, va, vb, vc, n, bus32.overflow, bus32.sum, exp[32], exp[31:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.carry_in = 1'b0;
    bus32.start = 1'b0; bus32.a = '0; bus32.b = '0; bus32.carry_in = 1'b0;
    test_reset;
    test_zeros;
    test_large;
    test_ripple;
    test_collision;
    test_reset_mid;
    test_back_to_back;
    test_wide;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
